// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared segment constants, widths and helpers for the VGA timing generator
//   DEF_* : 1280x800 raster (1680 x 828 clocks/lines)
//   ALT_* : 640x480 raster (800 x 525 clocks/lines)
package vga_timing_pkg;
    localparam int DEF_H_SYNC = 136;
    localparam int DEF_H_BP = 200;
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP = 64;
    localparam int DEF_V_SYNC = 3;
    localparam int DEF_V_BP = 24;
    localparam int DEF_V_ACTIVE = 800;
    localparam int DEF_V_FP = 1;
    localparam int ALT_H_SYNC = 96;
    localparam int ALT_H_BP = 48;
    localparam int ALT_H_ACTIVE = 640;
    localparam int ALT_H_FP = 16;
    localparam int ALT_V_SYNC = 2;
    localparam int ALT_V_BP = 33;
    localparam int ALT_V_ACTIVE = 480;
    localparam int ALT_V_FP = 10;
    localparam int H_CNT_MAX = 2048;
    localparam int V_CNT_MAX = 1024;
    localparam int MAX_PIX_LAT = 8;
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;
    function automatic int seg_total(input int s, input int bp, input int act, input int fp);
        return s + bp + act + fp;
    endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit shift register of DEPTH stages with enable and synchronous clear
//   clk, rst : clock, synchronous active-high clear of every stage
//   en       : shift enable; stages hold when low
//   d, q     : input word, word delayed by DEPTH enabled clocks (DEPTH=0 passes d through)
module vga_delay_line #(
    parameter int W = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, en};
            assign q = d;
        end else begin : g_sr
            logic [W-1:0] sr [DEPTH];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
                end else if (en) begin
                    sr[0] <= d;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end
            assign q = sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with early pixel coordinates and latency-aligned sync/de/rgb
//   clk, rst, en   : pixel clock, synchronous active-high reset, count enable (low = hold all)
//   rgb_in         : {r,g,b} from renderer, valid PIX_LAT clocks after its coordinates
//   curr_x, curr_y : active-area coordinates (0 outside active), coord_vld flags them
//   frame_start    : pulse with (0,0); line_start : pulse with x=0 of each active line
//   hsync, vsync, de, pix_r/g/b : outputs aligned to rgb_in, lag coord_vld by PIX_LAT+1
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP = DEF_H_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP = DEF_V_FP,
    parameter bit H_POL = 1'b0,
    parameter bit V_POL = 1'b1,
    parameter int PIX_LAT = 1,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [3*CW-1:0] rgb_in,
    output logic [10:0]   curr_x,
    output logic [9:0]    curr_y,
    output logic          coord_vld,
    output logic          frame_start,
    output logic          line_start,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] pix_r,
    output logic [CW-1:0] pix_g,
    output logic [CW-1:0] pix_b
);
    localparam int H_TOT = seg_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOT = seg_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    generate
        if (H_TOT > H_CNT_MAX || V_TOT > V_CNT_MAX || PIX_LAT < 0 || PIX_LAT > MAX_PIX_LAT) begin : g_bad_cfg
            $error("vga_timing_gen: H_TOT/V_TOT exceed counter width or PIX_LAT out of 0..8");
        end
    endgenerate
    localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
    localparam logic [10:0] H_S = 11'(H_SYNC);
    localparam logic [10:0] HA0 = 11'(H_SYNC + H_BP);
    localparam logic [10:0] HA_LAST = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] V_S = 10'(V_SYNC);
    localparam logic [9:0] VA0 = 10'(V_SYNC + V_BP);
    localparam logic [9:0] VA_LAST = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    logic [10:0] hcnt;
    logic [9:0]  vcnt;
    logic        h_wrap, v_wrap, act;
    sync_t       s0, dl_q;
    always_comb begin
        h_wrap = hcnt == H_LAST;
        v_wrap = vcnt == V_LAST;
        act = hcnt >= HA0 && hcnt <= HA_LAST && vcnt >= VA0 && vcnt <= VA_LAST;
    end
    // vcnt only moves on the hcnt wrap, so vsync can only change at a line boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (en) begin
            hcnt <= h_wrap ? '0 : hcnt + 11'd1;
            if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 10'd1;
        end
    end
    // Stage 0: coordinates for the renderer plus raw (active-high) sync/de flags
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_x <= '0;
            curr_y <= '0;
            coord_vld <= 1'b0;
            frame_start <= 1'b0;
            line_start <= 1'b0;
            s0 <= '0;
        end else if (en) begin
            curr_x <= act ? hcnt - HA0 : '0;
            curr_y <= act ? vcnt - VA0 : '0;
            coord_vld <= act;
            frame_start <= act && hcnt == HA0 && vcnt == VA0;
            line_start <= act && hcnt == HA0;
            s0 <= sync_t'{hs: hcnt < H_S, vs: vcnt < V_S, de: act};
        end
    end
    vga_delay_line #(.W($bits(sync_t)), .DEPTH(PIX_LAT)) u_dl (
        .clk(clk),
        .rst(rst),
        .en(en),
        .d(s0),
        .q(dl_q)
    );
    // Polarity is applied only here so a cleared pipeline reads as inactive sync
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= ~H_POL;
            vsync <= ~V_POL;
            de <= 1'b0;
            {pix_r, pix_g, pix_b} <= '0;
        end else if (en) begin
            hsync <= dl_q.hs ? H_POL : ~H_POL;
            vsync <= dl_q.vs ? V_POL : ~V_POL;
            de <= dl_q.de;
            {pix_r, pix_g, pix_b} <= dl_q.de ? rgb_in : '0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default, small-raster and 640x480 timing generators
module tb_vga_timing_gen;
    import vga_timing_pkg::*;
    logic clk = 1'b0, rst = 1'b1, rst1 = 1'b1, en = 1'b1, en1 = 1'b1;
    logic [11:0] rgb0 = '0, rgb1, rgb2 = '0;
    logic [10:0] cx0, cx1, cx2;
    logic [9:0]  cy0, cy1, cy2;
    logic cv0, cv1, cv2, fs0, fs1, fs2, ls0, ls1, ls2;
    logic hs0, hs1, hs2, vs0, vs1, vs2, de0, de1, de2;
    logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
    logic [11:0] pipe [3];
    int pass_cnt = 0, chk_cnt = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_SYNC(DEF_H_SYNC), .H_BP(DEF_H_BP), .H_ACTIVE(DEF_H_ACTIVE), .H_FP(DEF_H_FP),
        .V_SYNC(DEF_V_SYNC), .V_BP(DEF_V_BP), .V_ACTIVE(DEF_V_ACTIVE), .V_FP(DEF_V_FP),
        .H_POL(1'b0), .V_POL(1'b1), .PIX_LAT(1), .CW(4)
    ) u0 (
        .clk(clk), .rst(rst), .en(en), .rgb_in(rgb0), .curr_x(cx0), .curr_y(cy0),
        .coord_vld(cv0), .frame_start(fs0), .line_start(ls0), .hsync(hs0), .vsync(vs0),
        .de(de0), .pix_r(r0), .pix_g(g0), .pix_b(b0)
    );

    // Small raster: 17 clocks x 10 lines, active 8x5 at (7,4), renderer latency 3
    vga_timing_gen #(
        .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(1),
        .H_POL(1'b0), .V_POL(1'b1), .PIX_LAT(3), .CW(4)
    ) u1 (
        .clk(clk), .rst(rst1), .en(en1), .rgb_in(rgb1), .curr_x(cx1), .curr_y(cy1),
        .coord_vld(cv1), .frame_start(fs1), .line_start(ls1), .hsync(hs1), .vsync(vs1),
        .de(de1), .pix_r(r1), .pix_g(g1), .pix_b(b1)
    );

    vga_timing_gen #(
        .H_SYNC(ALT_H_SYNC), .H_BP(ALT_H_BP), .H_ACTIVE(ALT_H_ACTIVE), .H_FP(ALT_H_FP),
        .V_SYNC(ALT_V_SYNC), .V_BP(ALT_V_BP), .V_ACTIVE(ALT_V_ACTIVE), .V_FP(ALT_V_FP),
        .H_POL(1'b1), .V_POL(1'b0), .PIX_LAT(0), .CW(4)
    ) u2 (
        .clk(clk), .rst(rst), .en(en), .rgb_in(rgb2), .curr_x(cx2), .curr_y(cy2),
        .coord_vld(cv2), .frame_start(fs2), .line_start(ls2), .hsync(hs2), .vsync(vs2),
        .de(de2), .pix_r(r2), .pix_g(g2), .pix_b(b2)
    );

    // Renderer model for u1: colour derived from coordinates, 3 enabled clocks late
    always @(posedge clk) begin
        if (rst1) begin
            for (int i = 0; i < 3; i++) pipe[i] <= '0;
        end else if (en1) begin
            pipe[0] <= {cx1[3:0], cy1[3:0], 4'hA};
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
    end
    assign rgb1 = pipe[2];

    // Raster position n of the small raster -> {vld, fs, ls, hs_act, vs_act, x[10:0], y[9:0]}
    function automatic logic [25:0] mdl(input int n);
        int h, v;
        logic a;
        if (n < 0) return '0;
        h = n % 17;
        v = (n / 17) % 10;
        a = h >= 7 && h <= 14 && v >= 4 && v <= 8;
        return {a, h == 7 && v == 4, h == 7 && a, h < 4, v < 2, 11'(a ? h - 7 : 0), 10'(a ? v - 4 : 0)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rst1 = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({hs0, vs0, de0, cv0, fs0, ls0} !== 6'b100000) $display("FAIL reset_u0_flags: got %b expected 100000", {hs0, vs0, de0, cv0, fs0, ls0});
        else pass_cnt++;
        chk_cnt++;
        if ({cx0, cy0, r0, g0, b0} !== '0) $display("FAIL reset_u0_data: got %h expected 0", {cx0, cy0, r0, g0, b0});
        else pass_cnt++;
        chk_cnt++;
        if ({hs1, vs1, de1, cv1, fs1, ls1, cx1, cy1, r1, g1, b1} !== {1'b1, 38'b0}) $display("FAIL reset_u1: got %h", {hs1, vs1, de1, cv1, fs1, ls1, cx1, cy1, r1, g1, b1});
        else pass_cnt++;
        chk_cnt++;
        if ({hs2, vs2, de2} !== 3'b010) $display("FAIL reset_u2_pol: got %b expected 010", {hs2, vs2, de2});
        else pass_cnt++;
        rst = 1'b0;
        rst1 = 1'b0;
    endtask

    task automatic test_default_sync();
        int t = 0, w = 0;
        while (hs0 !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        chk_cnt++;
        if (t !== 3) $display("FAIL hsync_first_latency: got %0d expected 3", t);
        else pass_cnt++;
        chk_cnt++;
        if (vs0 !== 1'b1) $display("FAIL vsync_at_frame_start: got %b expected 1", vs0);
        else pass_cnt++;
        while (hs0 === 1'b0 && w < 2000) begin @(negedge clk); w++; end
        chk_cnt++;
        if (w !== 136) $display("FAIL hsync_width: got %0d expected 136", w);
        else pass_cnt++;
        while (hs0 === 1'b1 && w < 2000) begin @(negedge clk); w++; end
        chk_cnt++;
        if (w !== 1680) $display("FAIL hsync_period: got %0d expected 1680", w);
        else pass_cnt++;
        while (vs0 === 1'b1 && w < 6000) begin @(negedge clk); w++; end
        chk_cnt++;
        if (w !== 5040) $display("FAIL vsync_width: got %0d expected 5040", w);
        else pass_cnt++;
        chk_cnt++;
        if (hs0 !== 1'b0) $display("FAIL vsync_edge_at_line_wrap: hsync got %b expected 0", hs0);
        else pass_cnt++;
    endtask

    task automatic test_alt_polarity();
        int t = 0, w = 0;
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({hs2, vs2} !== 2'b01) $display("FAIL alt_reset_pol: got %b expected 01", {hs2, vs2});
        else pass_cnt++;
        rst = 1'b0;
        while (hs2 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        chk_cnt++;
        if (t !== 2 || vs2 !== 1'b0) $display("FAIL alt_first_sync: got lat %0d vs %b expected 2 0", t, vs2);
        else pass_cnt++;
        while (hs2 === 1'b1 && w < 1000) begin @(negedge clk); w++; end
        chk_cnt++;
        if (w !== 96) $display("FAIL alt_hsync_width: got %0d expected 96", w);
        else pass_cnt++;
        while (hs2 === 1'b0 && w < 1000) begin @(negedge clk); w++; end
        chk_cnt++;
        if (w !== 800) $display("FAIL alt_hsync_period: got %0d expected 800", w);
        else pass_cnt++;
        while (vs2 === 1'b0 && w < 3000) begin @(negedge clk); w++; end
        chk_cnt++;
        if (w !== 1600) $display("FAIL alt_vsync_width: got %0d expected 1600", w);
        else pass_cnt++;
    endtask

    task automatic test_frame_and_pixels();
        logic [25:0] e, a;
        int vld_cnt = 0, fs_cnt = 0;
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        for (int k = 1; k <= 360; k++) begin
            @(negedge clk);
            e = mdl(k - 1);
            a = mdl(k - 5);
            if (k <= 170 && cv1 === 1'b1) vld_cnt++;
            if (fs1 === 1'b1) fs_cnt++;
            chk_cnt++;
            if ({cv1, fs1, ls1, cx1, cy1} !== {e[25:23], e[20:0]})
                $display("FAIL coords k=%0d: got %h expected %h", k, {cv1, fs1, ls1, cx1, cy1}, {e[25:23], e[20:0]});
            else pass_cnt++;
            chk_cnt++;
            if ({hs1, vs1, de1, r1, g1, b1} !== {~a[22], a[21], a[25], a[25] ? {a[13:10], a[3:0], 4'hA} : 12'h000})
                $display("FAIL aligned k=%0d: got %h expected %h", k, {hs1, vs1, de1, r1, g1, b1},
                         {~a[22], a[21], a[25], a[25] ? {a[13:10], a[3:0], 4'hA} : 12'h000});
            else pass_cnt++;
        end
        chk_cnt++;
        if (vld_cnt !== 40) $display("FAIL coord_vld_per_frame: got %0d expected 40", vld_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (fs_cnt !== 2) $display("FAIL frame_start_count: got %0d expected 2", fs_cnt);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int t = 0, k = 0;
        logic leak = 1'b0;
        while (!(cv1 === 1'b1 && cx1 == 11'd5 && cy1 == 10'd3) && t < 400) begin @(negedge clk); t++; end
        chk_cnt++;
        if (t >= 400) $display("FAIL midreset_reach_5_3: got timeout expected position found");
        else pass_cnt++;
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk_cnt++;
        if ({hs1, vs1, de1, cv1, fs1, ls1, cx1, cy1, r1, g1, b1} !== {1'b1, 38'b0})
            $display("FAIL midreset_outputs: got %h expected %h", {hs1, vs1, de1, cv1, fs1, ls1, cx1, cy1, r1, g1, b1}, {1'b1, 38'b0});
        else pass_cnt++;
        while (fs1 !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
            if (de1 === 1'b1 || (cv1 === 1'b1 && fs1 !== 1'b1) || ls1 === 1'b1 && fs1 !== 1'b1) leak = 1'b1;
        end
        chk_cnt++;
        if (k !== 76) $display("FAIL midreset_frame_start_delay: got %0d expected 76", k);
        else pass_cnt++;
        chk_cnt++;
        if (leak !== 1'b0) $display("FAIL midreset_partial_leak: got %b expected 0", leak);
        else pass_cnt++;
    endtask

    task automatic test_enable_gaps();
        logic [25:0] e, a;
        logic [38:0] cur, prev;
        int j = 0, c = 0, fs_cnt = 0;
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        prev = {cv1, fs1, ls1, cx1, cy1, hs1, vs1, de1, r1, g1, b1};
        while (j < 400 && c < 3000) begin
            en1 = 1'($urandom_range(0, 1));
            @(negedge clk);
            c++;
            cur = {cv1, fs1, ls1, cx1, cy1, hs1, vs1, de1, r1, g1, b1};
            if (en1) begin
                j++;
                e = mdl(j - 1);
                a = mdl(j - 5);
                if (fs1 === 1'b1) fs_cnt++;
                chk_cnt++;
                if (cur !== {e[25:23], e[20:0], ~a[22], a[21], a[25], a[25] ? {a[13:10], a[3:0], 4'hA} : 12'h000})
                    $display("FAIL en_step j=%0d: got %h expected %h", j, cur,
                             {e[25:23], e[20:0], ~a[22], a[21], a[25], a[25] ? {a[13:10], a[3:0], 4'hA} : 12'h000});
                else pass_cnt++;
            end else begin
                chk_cnt++;
                if (cur !== prev) $display("FAIL en_hold c=%0d: got %h expected %h", c, cur, prev);
                else pass_cnt++;
            end
            prev = cur;
        end
        en1 = 1'b1;
        chk_cnt++;
        if (j !== 400) $display("FAIL en_step_budget: got %0d expected 400", j);
        else pass_cnt++;
        chk_cnt++;
        if (fs_cnt !== 2) $display("FAIL en_frame_start_count: got %0d expected 2", fs_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_default_sync();
        test_alt_polarity();
        test_frame_and_pixels();
        test_mid_reset();
        test_enable_gaps();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
